// File: rtl/mips_pkg.sv
// Shared definitions for the single-issue MIPS core.
//   - opcode and funct encodings used by fetch, decode and control
//   - instruction field positions
//   - fetch front-end FSM state type
package mips_pkg;

    localparam int INSTR_W = 32;

    // Instruction field positions
    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int TARGET_MSB = 25;
    localparam int IMM_MSB    = 15;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Fetch FSM: waiting on memory, or holding an instruction for decode
    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection for a retiring instruction.
// Ports:
//   pc_plus4  in  WIDTH  address following the retiring instruction
//   instr     in  WIDTH  retiring instruction word
//   Jump      in  1      take the J-format target (highest priority)
//   Branch    in  1      conditional branch instruction
//   Zero      in  1      ALU zero flag; branch taken when Branch && Zero
//   next_pc   out WIDTH  address of the next instruction to fetch
module pc_next_logic
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] instr,
    input  logic             Jump,
    input  logic             Branch,
    input  logic             Zero,
    output logic [WIDTH-1:0] next_pc
);

    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] branch_target;
    // Opcode bits play no part in target arithmetic
    logic             unused_op_bits;

    assign imm_sext[IMM_MSB:0] = instr[IMM_MSB:0];

    genvar gi;
    generate
        for (gi = IMM_MSB + 1; gi < WIDTH; gi++) begin : g_sext
            assign imm_sext[gi] = instr[IMM_MSB];
        end
    endgenerate

    // Pseudo-direct jump: top nibble comes from the sequential address
    assign jump_target   = {pc_plus4[WIDTH-1:WIDTH-4], instr[TARGET_MSB:0], 2'b00};
    // Word offset; addition wraps naturally at WIDTH bits
    assign branch_target = pc_plus4 + {imm_sext[WIDTH-3:0], 2'b00};

    assign unused_op_bits = ^instr[OP_MSB:OP_LSB];

    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = jump_target;
        end else if (Branch && Zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: holds the PC, fetches one word at a time
// over a req/ack memory handshake and presents it to decode over a
// valid/ready handshake. On retire the PC advances to the sequential,
// branch or jump target.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/imem_addr        fetch request and address (= pc)
//   imem_ack/imem_rdata       memory response, accepted only while requesting
//   instr/OP/Funct            captured instruction and its opcode/funct fields
//   instr_valid/instr_ready   decode handshake; both high = retire
//   Jump/Branch/Zero          control inputs, sampled only on retire
//   pc/pc_plus4               address of held instruction and its successor
//   instr_count               retired-instruction counter (wraps)
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [5:0]       OP,
    output logic [5:0]       Funct,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             Jump,
    input  logic             Branch,
    input  logic             Zero,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] instr_count
);

    fetch_state_t     state_reg, state_next;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] instr_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] pc_next;
    logic             capture;
    logic             retire;

    assign pc_plus4 = pc_reg + WIDTH'(4);

    pc_next_logic #(
        .WIDTH (WIDTH)
    ) u_pc_next (
        .pc_plus4 (pc_plus4),
        .instr    (instr_reg),
        .Jump     (Jump),
        .Branch   (Branch),
        .Zero     (Zero),
        .next_pc  (pc_next)
    );

    always_comb begin
        state_next  = state_reg;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        retire      = 1'b0;
        case (state_reg)
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    capture    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                // imem_ack is deliberately ignored here
                if (instr_ready) begin
                    retire     = 1'b1;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_REQ;
            pc_reg    <= RESET_PC;
            instr_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                instr_reg <= imem_rdata;
            end
            // Jump/Branch/Zero only influence state here, so their value
            // in any other cycle is irrelevant
            if (retire) begin
                pc_reg    <= pc_next;
                count_reg <= count_reg + WIDTH'(1);
            end
        end
    end

    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign OP          = instr_reg[OP_MSB:OP_LSB];
    assign Funct       = instr_reg[FUNCT_MSB:FUNCT_LSB];
    assign instr_count = count_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  OP;
    logic [5:0]  Funct;
    logic        instr_valid;
    logic        instr_ready;
    logic        Jump;
    logic        Branch;
    logic        Zero;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .OP          (OP),
        .Funct       (Funct),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .Jump        (Jump),
        .Branch      (Branch),
        .Zero        (Zero),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_count (instr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst         = 1'b1;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        Jump        = 1'b0;
        Branch      = 1'b0;
        Zero        = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req",   {31'd0, imem_req},    32'd1);
        check("rst_addr",  imem_addr,            32'h0);
        check("rst_count", instr_count,          32'd0);
        check("rst_instr", instr,                32'd0);
        $display("reset: addr=0x%08h count=%0d", imem_addr, instr_count);
    endtask

    // Wait wait_cycles without ack, then ack with word; check capture.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int wait_cycles);
        logic [31:0] w;
        w = word;
        for (int i = 0; i < wait_cycles; i++) begin
            check("wait_req",   {31'd0, imem_req},    32'd1);
            check("wait_addr",  imem_addr,            addr);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        check("req",      {31'd0, imem_req}, 32'd1);
        check("addr",     imem_addr,         addr);
        check("pc_plus4", pc_plus4,          addr + 32'd4);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("valid", {31'd0, instr_valid}, 32'd1);
        check("noreq", {31'd0, imem_req},    32'd0);
        check("instr", instr,                word);
        check("pc",    pc,                   addr);
        check("op",    {26'd0, OP},          {26'd0, w[31:26]});
        check("funct", {26'd0, Funct},       {26'd0, w[5:0]});
        $display("fetch: addr=0x%08h word=0x%08h wait=%0d", addr, word, wait_cycles);
    endtask

    task automatic retire(input logic j, input logic b, input logic z,
                          input logic [31:0] next_addr, input logic [31:0] cnt);
        instr_ready = 1'b1;
        Jump        = j;
        Branch      = b;
        Zero        = z;
        tick();
        instr_ready = 1'b0;
        Jump        = 1'b0;
        Branch      = 1'b0;
        Zero        = 1'b0;
        check("ret_valid", {31'd0, instr_valid}, 32'd0);
        check("ret_req",   {31'd0, imem_req},    32'd1);
        check("next_addr", imem_addr,            next_addr);
        check("count",     instr_count,          cnt);
        $display("retire: J=%0b B=%0b Z=%0b next=0x%08h count=%0d", j, b, z, imem_addr, instr_count);
    endtask

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        instr_ready = 1'b0;
        Jump       = 1'b0;
        Branch     = 1'b0;
        Zero       = 1'b0;

        // 1: sequential fetch, ack immediately
        do_reset();
        fetch(32'h0, 32'h0085_1020, 0);
        check("rtype_op",    {26'd0, OP},    32'h00);
        check("rtype_funct", {26'd0, Funct}, 32'h20);
        retire(1'b0, 1'b0, 1'b0, 32'h4, 32'd1);
        fetch(32'h4, 32'h2001_0005, 0);
        retire(1'b0, 1'b0, 1'b0, 32'h8, 32'd2);
        fetch(32'h8, 32'h8C22_0004, 0);
        retire(1'b0, 1'b0, 1'b0, 32'hC, 32'd3);

        // 2: slow memory, ack after 3 idle cycles
        do_reset();
        fetch(32'h0, 32'h0043_0822, 3);
        retire(1'b0, 1'b0, 1'b0, 32'h4, 32'd1);

        // 3: jump wins over a simultaneous taken branch
        do_reset();
        fetch(32'h0, 32'h0800_0010, 0);
        retire(1'b1, 1'b1, 1'b1, 32'h40, 32'd1);

        // 4: BEQ with offset -2 words at pc 0x10
        do_reset();
        fetch(32'h0, 32'h0000_0020, 0);
        retire(1'b0, 1'b0, 1'b0, 32'h4, 32'd1);
        fetch(32'h4, 32'h0000_0020, 0);
        retire(1'b0, 1'b0, 1'b0, 32'h8, 32'd2);
        fetch(32'h8, 32'h0000_0020, 0);
        retire(1'b0, 1'b0, 1'b0, 32'hC, 32'd3);
        fetch(32'hC, 32'h0000_0020, 0);
        retire(1'b0, 1'b0, 1'b0, 32'h10, 32'd4);
        fetch(32'h10, 32'h1000_FFFE, 0);
        retire(1'b0, 1'b1, 1'b1, 32'hC, 32'd5);
        fetch(32'hC, 32'h0000_0020, 0);
        retire(1'b0, 1'b0, 1'b0, 32'h10, 32'd6);
        fetch(32'h10, 32'h1000_FFFE, 0);
        retire(1'b0, 1'b1, 1'b0, 32'h14, 32'd7);

        // 5: decode stall with a stray ack, then reset during ready
        fetch(32'h14, 32'h2001_0005, 0);
        for (int i = 0; i < 4; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hFFFF_FFFF;
            tick();
            check("stall_instr", instr,                32'h2001_0005);
            check("stall_op",    {26'd0, OP},          32'h08);
            check("stall_funct", {26'd0, Funct},       32'h05);
            check("stall_pc",    pc,                   32'h14);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_req",   {31'd0, imem_req},    32'd0);
            $display("stall: cycle=%0d instr=0x%08h pc=0x%08h", i, instr, pc);
        end
        imem_ack    = 1'b0;
        rst         = 1'b1;
        instr_ready = 1'b1;
        tick();
        rst         = 1'b0;
        instr_ready = 1'b0;
        check("rstrdy_valid", {31'd0, instr_valid}, 32'd0);
        check("rstrdy_addr",  imem_addr,            32'h0);
        check("rstrdy_count", instr_count,          32'd0);
        $display("reset during ready: addr=0x%08h count=%0d", imem_addr, instr_count);

        // 6: branch back to 0xFFFF_FFFC, then sequential wrap to 0
        fetch(32'h0, 32'h1000_FFFE, 0);
        retire(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'd1);
        fetch(32'hFFFF_FFFC, 32'h0000_0020, 0);
        check("wrap_plus4", pc_plus4, 32'h0);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
